// File: rtl/seq_decoder_pkg.sv
// ----------------------------------------------------------------------------
// seq_decoder_pkg : shared types and sizing helpers for the sequencing decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seq_decoder_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int SEL_W_DEFAULT   = 5;
   localparam int DWELL_W_DEFAULT = 4;

   function automatic int out_width(input int sel_w);
      return 1 << sel_w;
   endfunction

   localparam int OUT_W_DEFAULT = out_width(SEL_W_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/seq_decoder_if.sv
// ----------------------------------------------------------------------------
// seq_decoder_if : control, select handshake and decoded-output bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface seq_decoder_if
   import seq_decoder_pkg::*;
#(
   parameter int SEL_W   = SEL_W_DEFAULT,
   parameter int DWELL_W = DWELL_W_DEFAULT
);
   localparam int OUT_W = out_width(SEL_W);

   logic               en;
   logic               mode;
   logic               sel_valid;
   logic               sel_ready;
   logic [SEL_W-1:0]   sel;
   logic [DWELL_W-1:0] dwell;
   logic               start;
   logic               stop;
   logic [OUT_W-1:0]   dec_out;
   logic [SEL_W-1:0]   cur_idx;
   logic               busy;
   logic               wrap;

   modport master (
      output en, mode, sel_valid, sel, dwell, start, stop,
      input  sel_ready, dec_out, cur_idx, busy, wrap
   );

   modport slave (
      input  en, mode, sel_valid, sel, dwell, start, stop,
      output sel_ready, dec_out, cur_idx, busy, wrap
   );

endinterface

`default_nettype wire

// File: rtl/seq_decoder_onehot_dec.sv
// ----------------------------------------------------------------------------
// onehot_dec : combinational SEL_W-to-2^SEL_W one-hot decoder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module onehot_dec #(
   parameter int SEL_W = 5
) (
   input  logic [SEL_W-1:0]        code,
   output logic [(1<<SEL_W)-1:0]   onehot
);

   for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_bit
      assign onehot[i] = (code == SEL_W'(i));
   end

endmodule

`default_nettype wire

// File: rtl/seq_decoder.sv
// ----------------------------------------------------------------------------
// seq_decoder : registered one-hot decoder with direct load and self-sweeping
// scan; define SEQ_DECODER_ONESHOT_EN for a single sweep per start.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter int SEL_W   = SEL_W_DEFAULT,
   parameter int DWELL_W = DWELL_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   seq_decoder_if.slave bus
);

   localparam int OUT_W = out_width(SEL_W);

   state_t             state, state_nx;
   logic [OUT_W-1:0]   dec_reg, dec_nx;
   logic [SEL_W-1:0]   idx, idx_nx;
   logic [DWELL_W-1:0] cnt, cnt_nx;
   logic [DWELL_W-1:0] dwell_lat, dwell_lat_nx;
   logic               wrap_r, wrap_nx;
   logic               rdy_r;
   logic               sel_ok;
   logic [SEL_W-1:0]   dec_code;
   logic [OUT_W-1:0]   dec_code_oh;

   assign sel_ok = rdy_r && (state == IDLE) && !bus.mode;

   // The single decoder sees the code that the next dec_reg value could take.
   always_comb begin
      dec_code = idx + SEL_W'(1);
      if (state == IDLE) begin
         dec_code = bus.mode ? '0 : bus.sel;
      end
   end

   onehot_dec #(.SEL_W(SEL_W)) u_onehot_dec (
      .code   (dec_code),
      .onehot (dec_code_oh)
   );

   always_comb begin
      state_nx     = state;
      dec_nx       = dec_reg;
      idx_nx       = idx;
      cnt_nx       = cnt;
      dwell_lat_nx = dwell_lat;
      wrap_nx      = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.mode) begin
               if (bus.sel_valid && sel_ok) begin
                  idx_nx = bus.sel;
                  dec_nx = dec_code_oh;
               end
            end else if (bus.start && !bus.stop) begin
               state_nx     = SCAN;
               idx_nx       = '0;
               dec_nx       = dec_code_oh;
               cnt_nx       = bus.dwell;
               dwell_lat_nx = bus.dwell;
            end
         end
         SCAN: begin
            if (bus.stop) begin
               state_nx = IDLE;
               dec_nx   = '0;
               idx_nx   = '0;
               cnt_nx   = '0;
            end else if (cnt == '0) begin
               idx_nx = dec_code;
               dec_nx = dec_code_oh;
               cnt_nx = dwell_lat;
               if (&idx) begin
                  wrap_nx = 1'b1;
`ifdef SEQ_DECODER_ONESHOT_EN
                  state_nx = IDLE;
                  dec_nx   = '0;
                  idx_nx   = '0;
                  cnt_nx   = '0;
`endif
               end
            end else begin
               cnt_nx = cnt - DWELL_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            dec_nx   = '0;
            idx_nx   = '0;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dec_reg   <= '0;
         idx       <= '0;
         cnt       <= '0;
         dwell_lat <= '0;
         wrap_r    <= 1'b0;
         rdy_r     <= 1'b0;
      end else begin
         state     <= state_nx;
         dec_reg   <= dec_nx;
         idx       <= idx_nx;
         cnt       <= cnt_nx;
         dwell_lat <= dwell_lat_nx;
         wrap_r    <= wrap_nx;
         rdy_r     <= 1'b1;
      end
   end

   assign bus.sel_ready = sel_ok;
   assign bus.dec_out   = bus.en ? dec_reg : '0;
   assign bus.cur_idx   = idx;
   assign bus.busy      = (state == SCAN);
   assign bus.wrap      = wrap_r;

endmodule

`default_nettype wire

// File: tb/tb_seq_decoder.sv
// ----------------------------------------------------------------------------
// tb_seq_decoder : directed vector table plus scan/stop/reset sequences
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_decoder;

   localparam int SEL_W   = 5;
   localparam int DWELL_W = 4;
   localparam int OUT_W   = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   seq_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

   seq_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             mode;
      logic             en;
      logic             valid;
      logic [SEL_W-1:0] sel;
      logic             exp_ready;
      logic [OUT_W-1:0] exp_dec;
      logic [SEL_W-1:0] exp_idx;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_scan(input logic [DWELL_W-1:0] d);
      bus.mode  = 1'b1;
      bus.dwell = d;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic stop_scan;
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("stop_busy", bus.busy, 0);
   endtask

   initial begin
      int wraps;
      int exp_idx;
      logic exp_busy;
      logic [OUT_W-1:0] exp_dec;

      vecs[0] = '{1'b0, 1'b1, 1'b1, 5'd3,  1'b1, 32'h0000_0008, 5'd3};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 32'h0000_0001, 5'd0};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 5'd31, 1'b1, 32'h8000_0000, 5'd31};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd5,  1'b1, 32'h8000_0000, 5'd31};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 5'd7,  1'b1, 32'h0000_0000, 5'd7};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b1, 32'h0000_0080, 5'd7};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 5'd9,  1'b0, 32'h0000_0080, 5'd7};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd16, 1'b1, 32'h0001_0000, 5'd16};

      rst = 1'b1;
      bus.en = 1'b1; bus.mode = 1'b0; bus.sel_valid = 1'b0; bus.sel = '0;
      bus.dwell = '0; bus.start = 1'b0; bus.stop = 1'b0;
      #2;
      check("rst_ready", bus.sel_ready, 0);
      check("rst_dec", bus.dec_out, 0);
      check("rst_busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      tick();
      check("post_rst_ready", bus.sel_ready, 1);
      check("post_rst_idx", bus.cur_idx, 0);

      // Direct-mode vector table
      for (int i = 0; i < 8; i++) begin
         bus.mode = vecs[i].mode; bus.en = vecs[i].en;
         bus.sel_valid = vecs[i].valid; bus.sel = vecs[i].sel;
         #1;
         check($sformatf("vec%0d_ready", i), bus.sel_ready, vecs[i].exp_ready);
         tick();
         check($sformatf("vec%0d_dec", i), bus.dec_out, vecs[i].exp_dec);
         check($sformatf("vec%0d_idx", i), bus.cur_idx, vecs[i].exp_idx);
      end

      // Back-to-back direct sweep, one code per cycle
      bus.mode = 1'b0; bus.en = 1'b1;
      for (int s = 0; s < OUT_W; s++) begin
         bus.sel_valid = 1'b1; bus.sel = SEL_W'(s);
         tick();
         exp_dec = OUT_W'(1) << s;
         check($sformatf("sweep%0d", s), bus.dec_out, exp_dec);
      end
      bus.sel_valid = 1'b0;

      // Scan with dwell=2: 3 cycles per index, wrap after 96 cycles
      wraps = 0;
      start_scan(4'd2);
      for (int k = 0; k < 100; k++) begin
`ifdef SEQ_DECODER_ONESHOT_EN
         exp_busy = (k < 96);
         exp_idx  = (k < 96) ? (k / 3) % OUT_W : 0;
         exp_dec  = (k < 96) ? (OUT_W'(1) << exp_idx) : '0;
`else
         exp_busy = 1'b1;
         exp_idx  = (k / 3) % OUT_W;
         exp_dec  = OUT_W'(1) << exp_idx;
`endif
         if (bus.wrap) wraps++;
         check($sformatf("scan2_idx_k%0d", k), bus.cur_idx, exp_idx);
         check($sformatf("scan2_dec_k%0d", k), bus.dec_out, exp_dec);
         check($sformatf("scan2_wrap_k%0d", k), bus.wrap, (k == 96));
         check($sformatf("scan2_busy_k%0d", k), bus.busy, exp_busy);
         tick();
      end
      check("scan2_wrap_count", wraps, 1);
      stop_scan();

      // en=0 for 10 cycles mid-scan; counter keeps running
      start_scan(4'd1);
      repeat (3) tick();
      check("en_idx_before", bus.cur_idx, 1);
      bus.en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("en_gate%0d", i), bus.dec_out, 0);
         tick();
      end
      bus.en = 1'b1;
      #1;
      check("en_idx_after", bus.cur_idx, 6);
      check("en_dec_after", bus.dec_out, 32'h0000_0040);
      stop_scan();

      // dwell=0, stop at index 17, then start+stop together in IDLE
      start_scan(4'd0);
      repeat (17) tick();
      check("stop17_idx", bus.cur_idx, 17);
      bus.stop = 1'b1;
      tick();
      check("stop17_dec", bus.dec_out, 0);
      check("stop17_busy", bus.busy, 0);
      check("stop17_idx0", bus.cur_idx, 0);
      check("stop17_wrap", bus.wrap, 0);
      bus.start = 1'b1;
      tick();
      check("startstop_busy", bus.busy, 0);
      check("startstop_dec", bus.dec_out, 0);
      bus.start = 1'b0; bus.stop = 1'b0;
      bus.mode = 1'b0; bus.start = 1'b1;
      tick();
      check("start_mode0_busy", bus.busy, 0);
      bus.start = 1'b0;

      // stop coincident with the 31->0 wrap: no wrap pulse
      start_scan(4'd0);
      repeat (31) tick();
      check("stop31_idx", bus.cur_idx, 31);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("stop31_wrap", bus.wrap, 0);
      check("stop31_idx0", bus.cur_idx, 0);
      check("stop31_busy", bus.busy, 0);

      // mode change during scan is ignored
      start_scan(4'd0);
      bus.mode = 1'b0;
      tick();
      check("modechg_busy", bus.busy, 1);
      check("modechg_idx", bus.cur_idx, 1);
      check("modechg_ready", bus.sel_ready, 0);
      stop_scan();

`ifdef SEQ_DECODER_ONESHOT_EN
      wraps = 0;
      start_scan(4'd0);
      for (int k = 0; k < 34; k++) begin
         exp_dec = (k < 32) ? (OUT_W'(1) << k) : '0;
         if (bus.wrap) wraps++;
         check($sformatf("oneshot_dec_k%0d", k), bus.dec_out, exp_dec);
         check($sformatf("oneshot_busy_k%0d", k), bus.busy, (k < 32));
         tick();
      end
      check("oneshot_wraps", wraps, 1);
`endif

      // asynchronous reset mid-scan
      start_scan(4'd0);
      repeat (4) tick();
      #3 rst = 1'b1;
      #1;
      check("arst_dec", bus.dec_out, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_idx", bus.cur_idx, 0);
      check("arst_wrap", bus.wrap, 0);
      check("arst_ready", bus.sel_ready, 0);
      @(posedge clk);
      #2 rst = 1'b0; bus.mode = 1'b0;
      tick();
      check("arst_release_ready", bus.sel_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder. It generalises the fixed 3-to-8 and 5-to-32 decoders.
- Direct mode: loads a select code over a valid/ready handshake.
- Scan mode: an internal counter sweeps every output with a programmable dwell.
- Drives row/strobe selects in the decoder family and doubles as a self-sweeping stimulus source.

Parameters:
SEL_W, 5, select code width; OUT_W = 2^SEL_W outputs (default 32).
DWELL_W, 4, width of dwell count; each scan index is held dwell+1 cycles.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  output enable; 0 forces dec_out to all zeros (state unaffected).
mode  in  1  0 = direct, 1 = scan; sampled only in IDLE.
sel_valid  in  1  direct-mode select code valid.
sel_ready  out  1  block accepts sel this cycle.
sel  in  SEL_W  direct-mode select code.
dwell  in  DWELL_W  scan dwell, sampled on start.
start  in  1  begin scan (mode=1, IDLE only).
stop  in  1  abort scan.
dec_out  out  OUT_W  registered one-hot output, gated by en.
cur_idx  out  SEL_W  index currently decoded.
busy  out  1  high while in SCAN.
wrap  out  1  one-cycle pulse when the scan index wraps from OUT_W-1 back to 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; dec_reg=0; cur_idx=0; dwell_cnt=0; wrap=0; busy=0.
  - sel_ready=0 while rst is asserted, 1 from the first cycle after deassertion.
- States: IDLE, SCAN.
- IDLE, mode=0:
  - sel_ready=1.
  - On sel_valid&sel_ready: next edge sets dec_reg=one-hot(sel) and cur_idx=sel. Latency is 1 cycle.
  - dec_reg holds until the next accepted code or a scan start.
  - sel_valid without ready is ignored; no buffering.
- IDLE, mode=1:
  - sel_ready=0.
  - start=1 -> SCAN, cur_idx=0, dec_reg=bit0, dwell_cnt=dwell latched, busy=1 from the next cycle.
- SCAN:
  - dwell_cnt decrements each cycle.
  - At dwell_cnt==0: cur_idx increments modulo OUT_W, dec_reg follows, dwell_cnt reloads the latched dwell.
  - On the OUT_W-1 -> 0 transition, wrap=1 for exactly that cycle; the scan loops indefinitely.
- dwell=0: index advances every cycle; a full sweep takes OUT_W cycles.
- dwell=max (2^DWELL_W-1): each index is held 2^DWELL_W cycles.
- stop=1 in SCAN: next edge -> IDLE, dec_reg=0, cur_idx=0, busy=0, no wrap pulse.
  - stop has priority over a simultaneous advance or wrap.
- start and stop in IDLE together: stop wins; remain IDLE.
- start in SCAN, or start with mode=0: ignored.
- mode changes while in SCAN: ignored until the block returns to IDLE.
- Output gating: dec_out = en ? dec_reg : 0, combinational on the registered value.
  - en does not stall the scan; the counter keeps running.
- rst mid-scan: immediate return to the reset values above; no partial wrap pulse.
- Invariant: dec_out is 0 or exactly one-hot, every cycle.

Optional Feature:
SEQ_DECODER_ONESHOT_EN
- Defined: scan performs exactly one sweep. At the wrap point it pulses wrap, then returns to IDLE with dec_reg=0 and busy=0, instead of looping.
- Undefined: scan loops until stop.

Decomposition:
- Package seq_decoder_pkg: state enum (IDLE, SCAN); helper constant OUT_W derived from SEL_W.
- Sub-module onehot_dec (parameter SEL_W): purely combinational SEL_W-to-2^SEL_W decoder, instantiated once to feed dec_reg's next value.
- FSM, counters and handshake stay in seq_decoder.

Test Plan:
- Reset: assert rst mid-cycle -> dec_out=0, busy=0, cur_idx=0 asynchronously; sel_ready=1 on the first cycle after release.
- Direct sweep, SEL_W=5, mode=0: sel=0..31 with sel_valid each cycle -> dec_out=1<<sel one cycle after each acceptance; sel=3 gives 32'h0000_0008.
- Scan, dwell=2: start -> each index held 3 cycles; wrap pulses exactly once after 96 cycles; index 0 resumes next.
- dwell=0 with stop asserted at cur_idx=17 -> next edge dec_out=0, busy=0, no wrap pulse; a simultaneous start in IDLE is ignored.
- en=0 for 10 cycles mid-scan -> dec_out=0 throughout; when en returns to 1, cur_idx has advanced by 10/(dwell+1) indices.
- With SEQ_DECODER_ONESHOT_EN, dwell=0: start -> 32 one-hot outputs, a single wrap pulse, then busy=0 and dec_out=0.
